// File: rtl/ysyx_041461_mem_stage_pkg.sv
// Shared definitions for the MEM stage.
// Holds the MEM_ctrl operation encodings, the MEM FSM state codes, and
// small helpers that classify an operation and check its alignment.
package ysyx_041461_mem_stage_pkg;

    // MEM_ctrl operation encodings
    localparam logic [3:0] MEM_NOP = 4'd0;
    localparam logic [3:0] MEM_LB  = 4'd1;
    localparam logic [3:0] MEM_LH  = 4'd2;
    localparam logic [3:0] MEM_LW  = 4'd3;
    localparam logic [3:0] MEM_LD  = 4'd4;
    localparam logic [3:0] MEM_LBU = 4'd5;
    localparam logic [3:0] MEM_LHU = 4'd6;
    localparam logic [3:0] MEM_LWU = 4'd7;
    localparam logic [3:0] MEM_SB  = 4'd8;
    localparam logic [3:0] MEM_SH  = 4'd9;
    localparam logic [3:0] MEM_SW  = 4'd10;
    localparam logic [3:0] MEM_SD  = 4'd11;

    // MEM FSM state codes
    localparam logic [1:0] MEM_IDLE = 2'd0;
    localparam logic [1:0] MEM_REQ  = 2'd1;
    localparam logic [1:0] MEM_WAIT = 2'd2;
    localparam logic [1:0] MEM_DONE = 2'd3;

    function automatic logic is_load(input logic [3:0] ctrl);
        return (ctrl >= MEM_LB) && (ctrl <= MEM_LWU);
    endfunction

    function automatic logic is_store(input logic [3:0] ctrl);
        return (ctrl >= MEM_SB) && (ctrl <= MEM_SD);
    endfunction

    // log2 of the access width in bytes: 0=byte, 1=half, 2=word, 3=double
    function automatic logic [1:0] access_size(input logic [3:0] ctrl);
        logic [1:0] size;
        case (ctrl)
            MEM_LB, MEM_LBU, MEM_SB: size = 2'd0;
            MEM_LH, MEM_LHU, MEM_SH: size = 2'd1;
            MEM_LW, MEM_LWU, MEM_SW: size = 2'd2;
            default:                 size = 2'd3;
        endcase
        return size;
    endfunction

    function automatic logic is_aligned(input logic [3:0] ctrl, input logic [2:0] off);
        logic ok;
        case (access_size(ctrl))
            2'd0:    ok = 1'b1;
            2'd1:    ok = ~off[0];
            2'd2:    ok = (off[1:0] == 2'b00);
            default: ok = (off == 3'b000);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ysyx_041461_mem_stage_align.sv
// Combinational byte-lane logic for the MEM stage.
// Store side: shifts store data into its byte lanes and builds the strobe.
// Load side: shifts the returned doubleword down and sign/zero-extends it.
// Ports:
//   st_ctrl, st_off, st_data -> st_lane, st_strb   (store lane placement)
//   ld_ctrl, ld_off, ld_data -> ld_ext             (load extraction)
module ysyx_041461_mem_stage_align
    import ysyx_041461_mem_stage_pkg::*;
(
    input  logic [3:0]  st_ctrl,
    input  logic [2:0]  st_off,
    input  logic [63:0] st_data,
    output logic [63:0] st_lane,
    output logic [7:0]  st_strb,
    input  logic [3:0]  ld_ctrl,
    input  logic [2:0]  ld_off,
    input  logic [63:0] ld_data,
    output logic [63:0] ld_ext
);

    logic [7:0]  strb_base;
    logic [63:0] ld_shift;

    // Full-width shift: bytes above the access size still move up, but the
    // strobe keeps them from being written.
    assign st_lane  = st_data << {st_off, 3'b000};
    assign ld_shift = ld_data >> {ld_off, 3'b000};

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path leaves it unassigned and no latch is inferred.
        strb_base = 8'h00;
        st_strb   = 8'h00;
        case (access_size(st_ctrl))
            2'd0:    strb_base = 8'h01;
            2'd1:    strb_base = 8'h03;
            2'd2:    strb_base = 8'h0F;
            default: strb_base = 8'hFF;
        endcase
        if (is_store(st_ctrl)) begin
            st_strb = strb_base << st_off;
        end
    end

    always_comb begin
        ld_ext = 64'd0;
        case (ld_ctrl)
            MEM_LB:  ld_ext = {{56{ld_shift[7]}},  ld_shift[7:0]};
            MEM_LH:  ld_ext = {{48{ld_shift[15]}}, ld_shift[15:0]};
            MEM_LW:  ld_ext = {{32{ld_shift[31]}}, ld_shift[31:0]};
            MEM_LD:  ld_ext = ld_shift;
            MEM_LBU: ld_ext = {56'd0, ld_shift[7:0]};
            MEM_LHU: ld_ext = {48'd0, ld_shift[15:0]};
            MEM_LWU: ld_ext = {32'd0, ld_shift[31:0]};
            default: ld_ext = 64'd0;
        endcase
    end

endmodule

// File: rtl/ysyx_041461_mem_stage.sv
// MEM pipeline stage: issues one data-memory transaction per load/store over
// a req/gnt + rvalid handshake and returns extended load data to WB.
// Ports:
//   clk, rst (async, active-high)
//   MEM_valid_in, MEM_ctrl_in, MEM_addr_in, MEM_wdata_in : instruction in MEM
//   WB_enable_in                                          : WB captures this cycle
//   MEM_valid_out, MEM_rdata_out                          : to WB register
//   MEM_stall_req, MEM_misalign_out                       : pipeline control
//   dmem_req/we/addr/wdata/wstrb, dmem_gnt/rvalid/rdata   : data memory port
module ysyx_041461_mem_stage
    import ysyx_041461_mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_valid_in,
    input  logic [3:0]  MEM_ctrl_in,
    input  logic [63:0] MEM_addr_in,
    input  logic [63:0] MEM_wdata_in,
    input  logic        WB_enable_in,
    output logic        MEM_valid_out,
    output logic [63:0] MEM_rdata_out,
    output logic        MEM_stall_req,
    output logic        MEM_misalign_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    output logic [7:0]  dmem_wstrb,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [63:0] dmem_rdata
);

    logic [1:0]  state;
    logic [3:0]  ctrl_q;     // op being serviced, kept for load extension in DONE
    logic [2:0]  off_q;
    logic [63:0] rdata_q;

    logic        is_mem;
    logic        mem_op;
    logic        misaligned;
    logic [63:0] st_lane;
    logic [7:0]  st_strb;
    logic [63:0] ld_ext;

    assign is_mem     = MEM_valid_in && (is_load(MEM_ctrl_in) || is_store(MEM_ctrl_in));
    assign mem_op     = is_mem && is_aligned(MEM_ctrl_in, MEM_addr_in[2:0]);
    assign misaligned = is_mem && !is_aligned(MEM_ctrl_in, MEM_addr_in[2:0]);

    ysyx_041461_mem_stage_align u_align (
        .st_ctrl (MEM_ctrl_in),
        .st_off  (MEM_addr_in[2:0]),
        .st_data (MEM_wdata_in),
        .st_lane (st_lane),
        .st_strb (st_strb),
        .ld_ctrl (ctrl_q),
        .ld_off  (off_q),
        .ld_data (rdata_q),
        .ld_ext  (ld_ext)
    );

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the captured-data and dmem registers are reset too, so a
            // reset mid-transaction leaves the memory port fully quiet.
            state      <= MEM_IDLE;
            ctrl_q     <= MEM_NOP;
            off_q      <= 3'd0;
            rdata_q    <= 64'd0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 64'd0;
            dmem_wdata <= 64'd0;
            dmem_wstrb <= 8'h00;
        end else begin
            case (state)
                MEM_IDLE: begin
                    if (mem_op) begin
                        dmem_addr  <= {MEM_addr_in[63:3], 3'b000};
                        dmem_wdata <= st_lane;
                        dmem_wstrb <= st_strb;
                        dmem_we    <= is_store(MEM_ctrl_in);
                        ctrl_q     <= MEM_ctrl_in;
                        off_q      <= MEM_addr_in[2:0];
                        state      <= MEM_REQ;
                    end
                end
                MEM_REQ: begin
                    if (dmem_gnt) begin
                        state <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    // rvalid is only meaningful here; other states ignore it.
                    if (dmem_rvalid) begin
                        if (is_load(ctrl_q)) begin
                            rdata_q <= dmem_rdata;
                        end
                        state <= MEM_DONE;
                    end
                end
                default: begin
                    if (WB_enable_in) begin
                        state <= MEM_IDLE;
                    end
                end
            endcase
        end
    end

    assign dmem_req         = (state == MEM_REQ);
    assign MEM_stall_req    = ((state == MEM_IDLE) && mem_op) ||
                              (state == MEM_REQ) || (state == MEM_WAIT);
    assign MEM_misalign_out = (state == MEM_IDLE) && misaligned;
    assign MEM_rdata_out    = ((state == MEM_DONE) && is_load(ctrl_q)) ? ld_ext : 64'd0;

    // Non-memory and misaligned instructions pass straight through in IDLE.
    always_comb begin
        MEM_valid_out = 1'b0;
        case (state)
            MEM_IDLE: MEM_valid_out = mem_op ? 1'b0 : MEM_valid_in;
            MEM_DONE: MEM_valid_out = 1'b1;
            default:  MEM_valid_out = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_ysyx_041461_mem_stage.sv
// Self-checking bench for ysyx_041461_mem_stage: directed cases with literal
// expectations, a reset-in-WAIT case, then randomized traffic compared every
// cycle against a byte-level transaction model.
module tb_ysyx_041461_mem_stage;
    import ysyx_041461_mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MEM_valid_in = 1'b0;
    logic [3:0]  MEM_ctrl_in = 4'd0;
    logic [63:0] MEM_addr_in = 64'd0;
    logic [63:0] MEM_wdata_in = 64'd0;
    logic        WB_enable_in = 1'b0;
    logic        MEM_valid_out;
    logic [63:0] MEM_rdata_out;
    logic        MEM_stall_req;
    logic        MEM_misalign_out;
    logic        dmem_req;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic [7:0]  dmem_wstrb;
    logic        dmem_gnt = 1'b0;
    logic        dmem_rvalid = 1'b0;
    logic [63:0] dmem_rdata = 64'd0;

    always #5 clk = ~clk;

    ysyx_041461_mem_stage dut (
        .clk              (clk),
        .rst              (rst),
        .MEM_valid_in     (MEM_valid_in),
        .MEM_ctrl_in      (MEM_ctrl_in),
        .MEM_addr_in      (MEM_addr_in),
        .MEM_wdata_in     (MEM_wdata_in),
        .WB_enable_in     (WB_enable_in),
        .MEM_valid_out    (MEM_valid_out),
        .MEM_rdata_out    (MEM_rdata_out),
        .MEM_stall_req    (MEM_stall_req),
        .MEM_misalign_out (MEM_misalign_out),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_wdata       (dmem_wdata),
        .dmem_wstrb       (dmem_wstrb),
        .dmem_gnt         (dmem_gnt),
        .dmem_rvalid      (dmem_rvalid),
        .dmem_rdata       (dmem_rdata)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit m_is_ld(input logic [3:0] c);
        return (c == MEM_LB) || (c == MEM_LH) || (c == MEM_LW) || (c == MEM_LD) ||
               (c == MEM_LBU) || (c == MEM_LHU) || (c == MEM_LWU);
    endfunction

    function automatic bit m_is_st(input logic [3:0] c);
        return (c == MEM_SB) || (c == MEM_SH) || (c == MEM_SW) || (c == MEM_SD);
    endfunction

    function automatic int nbytes(input logic [3:0] c);
        if (c == MEM_LB || c == MEM_LBU || c == MEM_SB) return 1;
        if (c == MEM_LH || c == MEM_LHU || c == MEM_SH) return 2;
        if (c == MEM_LW || c == MEM_LWU || c == MEM_SW) return 4;
        return 8;
    endfunction

    // Store data placed byte by byte into lanes starting at off.
    function automatic logic [63:0] m_lane(input logic [63:0] wd, input int off);
        logic [63:0] r;
        r = 64'd0;
        for (int i = 0; i < 8; i++)
            if (i >= off) r[8*i +: 8] = wd[8*(i-off) +: 8];
        return r;
    endfunction

    function automatic logic [7:0] m_strb(input logic [3:0] c, input int off);
        logic [7:0] s;
        s = 8'h00;
        for (int i = 0; i < 8; i++)
            if (m_is_st(c) && i >= off && i < off + nbytes(c)) s[i] = 1'b1;
        return s;
    endfunction

    function automatic logic [63:0] m_load(input logic [3:0] c, input logic [63:0] rd, input int off);
        logic [63:0] r;
        int n;
        bit sgn, neg;
        r = 64'd0;
        if (!m_is_ld(c)) return r;
        n   = nbytes(c);
        sgn = (c == MEM_LB) || (c == MEM_LH) || (c == MEM_LW);
        neg = rd[8*(off+n-1) + 7];
        for (int i = 0; i < 8; i++) begin
            if (i < n)             r[8*i +: 8] = rd[8*(off+i) +: 8];
            else if (sgn && neg)   r[8*i +: 8] = 8'hFF;
        end
        return r;
    endfunction

    // ---------------- expectations + compare process ----------------
    bit          chk_en = 0;
    logic        e_valid, e_stall, e_mis, e_req, e_dm, e_we;
    logic [63:0] e_rdata, e_addr, e_wdata;
    logic [7:0]  e_strb;

    always @(negedge clk) begin
        if (chk_en) begin
            check("valid_out", MEM_valid_out, e_valid);
            check("stall_req", MEM_stall_req, e_stall);
            check("misalign", MEM_misalign_out, e_mis);
            check("dmem_req", dmem_req, e_req);
            check("rdata_out", MEM_rdata_out, e_rdata);
            if (e_dm) begin
                check("dmem_we", dmem_we, e_we);
                check("dmem_addr", dmem_addr, e_addr);
                check("dmem_wdata", dmem_wdata, e_wdata);
                check("dmem_wstrb", dmem_wstrb, e_strb);
            end
        end
    end

    // ---------------- observations for directed literal checks ----------------
    int          cyc, obs_lat, obs_stall_cnt, obs_req_cnt, obs_done_cnt;
    logic        obs_we, obs_mis, obs_valid;
    logic [63:0] obs_addr, obs_wdata, obs_rdata;
    logic [7:0]  obs_wstrb;

    task automatic tick();
        @(negedge clk);
        if (MEM_stall_req) obs_stall_cnt++;
        if (dmem_req) begin
            obs_req_cnt++;
            obs_we    = dmem_we;
            obs_addr  = dmem_addr;
            obs_wdata = dmem_wdata;
            obs_wstrb = dmem_wstrb;
        end
        if (MEM_valid_out) begin
            if (obs_lat < 0) obs_lat = cyc;
            obs_done_cnt++;
            obs_rdata = MEM_rdata_out;
        end
        obs_valid = MEM_valid_out;
        obs_mis   = MEM_misalign_out;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // One instruction through MEM. g/r/w: extra cycles before gnt, rvalid,
    // WB_enable. noise: stray rvalid/rdata outside the WAIT window.
    task automatic run_op(input logic v, input logic [3:0] c, input logic [63:0] a,
                          input logic [63:0] wd, input logic [63:0] rd,
                          input int g, input int r, input int w, input bit noise);
        int  n, off;
        bit  is_mem, memop;
        n      = nbytes(c);
        off    = int'(a[2:0]);
        is_mem = v && (m_is_ld(c) || m_is_st(c));
        memop  = is_mem && ((a % 64'(n)) == 64'd0);
        cyc = 0; obs_lat = -1; obs_stall_cnt = 0; obs_req_cnt = 0; obs_done_cnt = 0;
        obs_rdata = 64'd0;

        MEM_valid_in = v; MEM_ctrl_in = c; MEM_addr_in = a; MEM_wdata_in = wd;
        dmem_gnt = 1'b0; WB_enable_in = 1'b0;
        dmem_rvalid = noise ? 1'($urandom) : 1'b0;
        dmem_rdata  = {$urandom, $urandom};
        e_req = 0; e_dm = 0; e_rdata = 64'd0;
        chk_en = 1;

        if (!memop) begin
            e_valid = v; e_stall = 0; e_mis = is_mem;
            WB_enable_in = 1'b1;
            tick();
        end else begin
            e_valid = 0; e_stall = 1; e_mis = 0;
            e_we    = m_is_st(c);
            e_addr  = (a / 64'd8) * 64'd8;
            e_wdata = m_lane(wd, off);
            e_strb  = m_strb(c, off);
            tick();                                  // IDLE: issue
            e_req = 1; e_dm = 1;
            for (int k = 0; k <= g; k++) begin       // REQ
                dmem_gnt    = (k == g);
                dmem_rvalid = noise ? 1'($urandom) : 1'b0;
                dmem_rdata  = {$urandom, $urandom};
                tick();
            end
            dmem_gnt = 1'b0; e_req = 0;
            for (int k = 0; k <= r; k++) begin       // WAIT
                dmem_rvalid = (k == r);
                dmem_rdata  = (k == r) ? rd : {$urandom, $urandom};
                tick();
            end
            e_dm = 0; e_valid = 1; e_stall = 0;
            e_rdata = m_load(c, rd, off);
            for (int k = 0; k <= w; k++) begin       // DONE
                WB_enable_in = (k == w);
                dmem_rvalid  = noise ? 1'($urandom) : 1'b0;
                dmem_rdata   = {$urandom, $urandom};
                tick();
            end
        end
        WB_enable_in = 1'b0; dmem_rvalid = 1'b0;
    endtask

    initial begin
        logic        v;
        logic [3:0]  c;
        int          n, off;
        logic [63:0] a;

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        check("rst_dmem_req", dmem_req, 1'b0);
        check("rst_dmem_we", dmem_we, 1'b0);
        check("rst_dmem_addr", dmem_addr, 64'd0);
        check("rst_dmem_wdata", dmem_wdata, 64'd0);
        check("rst_dmem_wstrb", dmem_wstrb, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_valid", MEM_valid_out, 1'b0);
        check("post_rst_stall", MEM_stall_req, 1'b0);
        check("post_rst_mis", MEM_misalign_out, 1'b0);

        // ---- directed cases with literal expectations ----
        run_op(1, MEM_LD, 64'h8000_0008, 64'd0, 64'h1122_3344_5566_7788, 0, 0, 0, 0);
        check("ld_rdata", obs_rdata, 64'h1122_3344_5566_7788);
        check("ld_latency", 64'(obs_lat), 64'd3);
        check("ld_stall_cycles", 64'(obs_stall_cnt), 64'd3);
        check("ld_addr", obs_addr, 64'h8000_0008);

        run_op(1, MEM_LB, 64'h8000_0003, 64'd0, 64'h1234_5678_80AB_CDEF, 0, 0, 0, 0);
        check("lb_sext", obs_rdata, 64'hFFFF_FFFF_FFFF_FF80);
        run_op(1, MEM_LBU, 64'h8000_0003, 64'd0, 64'h1234_5678_80AB_CDEF, 0, 0, 0, 0);
        check("lbu_zext", obs_rdata, 64'h0000_0000_0000_0080);

        run_op(1, MEM_SH, 64'h8000_0006, 64'h0000_0000_0000_ABCD, 64'h5555_5555_5555_5555, 0, 0, 0, 0);
        check("sh_we", obs_we, 1'b1);
        check("sh_addr", obs_addr, 64'h8000_0000);
        check("sh_wstrb", obs_wstrb, 8'hC0);
        check("sh_wdata", obs_wdata, 64'hABCD_0000_0000_0000);
        check("sh_rdata_zero", obs_rdata, 64'd0);

        run_op(1, MEM_LW, 64'h8000_0002, 64'd0, 64'd0, 0, 0, 0, 0);
        check("lw_mis_flag", obs_mis, 1'b1);
        check("lw_mis_noreq", 64'(obs_req_cnt), 64'd0);
        check("lw_mis_nostall", 64'(obs_stall_cnt), 64'd0);
        check("lw_mis_valid", obs_valid, 1'b1);
        check("lw_mis_lat", 64'(obs_lat), 64'd0);

        run_op(1, MEM_LD, 64'h8000_0040, 64'd0, 64'hCAFE_F00D_0000_1111, 4, 0, 2, 0);
        check("slow_req_cycles", 64'(obs_req_cnt), 64'd5);
        check("slow_done_cycles", 64'(obs_done_cnt), 64'd3);
        check("slow_stall_cycles", 64'(obs_stall_cnt), 64'd7);
        check("slow_rdata", obs_rdata, 64'hCAFE_F00D_0000_1111);

        // ---- reset pulsed while in WAIT ----
        chk_en = 0;
        MEM_valid_in = 1'b1; MEM_ctrl_in = MEM_SD; MEM_addr_in = 64'h8000_0010;
        MEM_wdata_in = 64'hDEAD_BEEF_0123_4567;
        @(posedge clk); #1;                // now REQ
        dmem_gnt = 1'b1;
        @(posedge clk); #1;                // now WAIT
        dmem_gnt = 1'b0;
        @(negedge clk);
        check("wait_pre_we", dmem_we, 1'b1);
        check("wait_pre_stall", MEM_stall_req, 1'b1);
        rst = 1'b1; MEM_valid_in = 1'b0;
        #1;
        check("wait_rst_req", dmem_req, 1'b0);
        check("wait_rst_we", dmem_we, 1'b0);
        check("wait_rst_addr", dmem_addr, 64'd0);
        check("wait_rst_wdata", dmem_wdata, 64'd0);
        check("wait_rst_wstrb", dmem_wstrb, 8'h00);
        check("wait_rst_stall", MEM_stall_req, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        dmem_rvalid = 1'b1; dmem_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
        repeat (2) begin
            @(negedge clk);
            check("late_rvalid_valid", MEM_valid_out, 1'b0);
            check("late_rvalid_stall", MEM_stall_req, 1'b0);
            check("late_rvalid_req", dmem_req, 1'b0);
            check("late_rvalid_mis", MEM_misalign_out, 1'b0);
        end
        dmem_rvalid = 1'b0;
        @(posedge clk); #1;
        run_op(1, MEM_LHU, 64'h8000_0022, 64'd0, 64'h0000_0000_8001_0000, 1, 1, 1, 1);
        check("after_rst_lhu", obs_rdata, 64'h0000_0000_0000_8001);

        // ---- randomized traffic ----
        for (int i = 0; i < 300; i++) begin
            v   = ($urandom % 10) != 0;
            c   = 4'($urandom_range(0, 11));
            n   = nbytes(c);
            if ($urandom % 4 == 0) off = $urandom_range(0, 7);
            else                   off = $urandom_range(0, 8 / n - 1) * n;
            a   = 64'h8000_0000 + 64'($urandom_range(0, 255)) * 64'd8 + 64'(off);
            run_op(v, c, a, {$urandom, $urandom}, {$urandom, $urandom},
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), 1);
        end

        chk_en = 0;
        MEM_valid_in = 1'b0;
        @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_041461_mem_stage.md
YSYX_041461_MEM_STAGE -- requirements
Module: ysyx_041461_MEM_stage

Interface
REQ-001 SHALL have ports (name  direction  width  meaning): clk  in  1  clock; rst  in  1  reset, asynchronous, active-high.
REQ-002 SHALL have MEM_valid_in  in  1  instruction in MEM register is valid.
REQ-003 SHALL have MEM_ctrl_in  in  4  memory op: NOP, LB, LH, LW, LD, LBU, LHU, LWU, SB, SH, SW, SD.
REQ-004 SHALL have MEM_addr_in  in  64  effective address (EXE result); MEM_wdata_in  in  64  store data (rs2).
REQ-005 SHALL have WB_enable_in  in  1  WB register captures this cycle.
REQ-006 SHALL have MEM_valid_out  out  1  feeds WB register valid_fromMEM; MEM_rdata_out  out  64  extended load data.
REQ-007 SHALL have MEM_stall_req  out  1  freeze upstream stages; MEM_misalign_out  out  1  misaligned access flag.
REQ-008 SHALL have dmem_req  out  1; dmem_we  out  1; dmem_addr  out  64 (8-byte aligned); dmem_wdata  out  64; dmem_wstrb  out  8.
REQ-009 SHALL have dmem_gnt  in  1  request accepted; dmem_rvalid  in  1  read data / write ack; dmem_rdata  in  64.

Function
REQ-010 SHALL implement FSM IDLE, REQ, WAIT, DONE.
REQ-011 Memory op: valid, ctrl not NOP, address aligned (H: addr[0]=0; W: addr[1:0]=0; D: addr[2:0]=0).
REQ-012 IDLE: on memory op, register dmem_addr={addr[63:3],3'b0}, wdata, wstrb and we, then go to REQ; otherwise stay in IDLE.
REQ-013 REQ: dmem_req=1 with all dmem outputs stable; on dmem_gnt go to WAIT.
REQ-014 WAIT: dmem_req=0; on dmem_rvalid capture dmem_rdata (loads only) and go to DONE. dmem_rvalid outside WAIT SHALL be ignored.
REQ-015 DONE: MEM_valid_out=1; hold until WB_enable_in=1, then go to IDLE on the same edge.
REQ-016 MEM_stall_req=1 when a memory op is in IDLE, or the state is REQ or WAIT; otherwise 0.
REQ-017 MEM_valid_out SHALL be 0 in IDLE/REQ/WAIT for memory ops. For non-memory or misaligned instructions it SHALL equal MEM_valid_in combinationally.
REQ-018 Misaligned valid load/store: no dmem_req, MEM_misalign_out=1, MEM_stall_req=0, MEM_rdata_out=0.
REQ-019 Store lanes: off=addr[2:0]; dmem_wdata=wdata<<(8*off); dmem_wstrb = 0x01/0x03/0x0F/0xFF (B/H/W/D) << off; loads have wstrb=0.
REQ-020 Load data: (captured rdata>>(8*off)) truncated to size; sign-extended for LB/LH/LW, zero-extended for LBU/LHU/LWU.
REQ-021 MEM_rdata_out SHALL be 0 for stores and non-memory ops.
REQ-022 Minimum memory-op latency (gnt in first REQ cycle, rvalid the next cycle): MEM_valid_out high 3 cycles after the op enters IDLE.
REQ-023 An accepted request SHALL always complete: no abandon or flush of REQ/WAIT.

Reset
REQ-024 rst SHALL force IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, dmem_wstrb=0 and the captured data register to 0, including mid-REQ/WAIT.
REQ-025 After rst deasserts, MEM_valid_out, MEM_stall_req and MEM_misalign_out SHALL be 0 while MEM_valid_in=0.

Structure
REQ-026 MEM_ctrl encodings and FSM state codes SHALL live in the shared ysyx_041461 defines file alongside the existing WB/exception codes.
REQ-027 Lane shifting, strobe generation and load extension SHALL be a combinational sub-module ysyx_041461_MEM_align.
REQ-028 Total RTL SHALL be 120-400 lines.

Verification
REQ-029 LD 0x80000008, gnt immediate, rdata 0x1122334455667788 next cycle -> MEM_rdata_out=0x1122334455667788, valid_out 3 cycles after issue, stall high for exactly 3 cycles.
REQ-030 LB/LBU 0x80000003, rdata byte3=0x80 -> LB gives 0xFFFFFFFFFFFFFF80; LBU gives 0x0000000000000080.
REQ-031 SH 0x80000006, wdata 0xABCD -> dmem_we=1, dmem_addr=0x80000000, wstrb=0xC0, dmem_wdata=0xABCD000000000000.
REQ-032 LW 0x80000002 -> misalign_out=1, no dmem_req, stall=0, valid_out=1 same cycle.
REQ-033 gnt delayed 4 cycles, WB_enable_in low 2 cycles in DONE -> dmem outputs stable, req held, DONE held, no second request issued.
REQ-034 rst pulsed in WAIT -> IDLE, all dmem outputs 0; a late rvalid is ignored.
